// File: rtl/router_pkt_tx_if.sv
// Router input-port bus between the packet transmitter and the router.
//   data_out  : byte presented to the router data_in
//   pkt_valid : packet-valid qualifier for header and payload bytes
//   busy      : router back-pressure; a byte is accepted only while low
// Modports: master = transmitter side, slave = router side.
interface router_pkt_tx_if;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       busy;

    modport master (output data_out, output pkt_valid, input busy);
    modport slave  (input data_out, input pkt_valid, output busy);
endinterface

// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding the router input port.
// A payload is loaded into an internal buffer while idle.
// On start, the block sends three things in order:
//   - a header byte {length[5:0], dest[1:0]}
//   - the payload bytes
//   - an even-XOR parity byte over header and payload
// The router's busy signal stalls the sequence one byte at a time.
//
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   ld_en/ld_data: load one payload byte (IDLE only, ignored when full)
//   ld_count     : bytes loaded;  ld_full: ld_count == MAX_LEN
//   start/dest   : transmit request and destination (3 is illegal)
//   abort        : drop the packet in flight and empty the buffer
//   tx_active    : high outside IDLE;  done: pulse after the parity byte
//   err          : pulse for a rejected start
//   rtr          : router bus (data_out, pkt_valid, busy)
//
// Optional feature, macro ROUTER_TX_PARITY_INJ_EN:
//   Adds the input inj_err. When inj_err is high at the accepted start,
//   bit 0 of that packet's parity byte is inverted.
module router_pkt_tx #(
    parameter int MAX_LEN = 63
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ld_en,
    input  logic [7:0] ld_data,
    output logic [5:0] ld_count,
    output logic       ld_full,
    input  logic       start,
    input  logic [1:0] dest,
    input  logic       abort,
    output logic       tx_active,
    output logic       done,
    output logic       err,
`ifdef ROUTER_TX_PARITY_INJ_EN
    input  logic       inj_err,
`endif
    router_pkt_tx_if.master rtr
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PARITY  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t     state_r, state_nxt;
    logic [7:0] data_r, data_nxt;
    logic       valid_r, valid_nxt;
    logic [5:0] rd_ptr_r, rd_ptr_nxt;
    logic [5:0] ld_count_r, ld_count_nxt;
    logic [7:0] par_r, par_nxt;
    logic       err_r, err_nxt;
    logic       inj_r, inj_nxt;
    logic       wr_en_s;
    logic       ld_full_s;
    logic       start_ok_s;
    logic [7:0] header_s;
    logic [7:0] par_out_s;

    logic [7:0] buf_mem [0:MAX_LEN-1];

    assign ld_full_s  = (ld_count_r == 6'(MAX_LEN));
    assign start_ok_s = (ld_count_r != 6'd0) && (dest != 2'b11);
    assign header_s   = {ld_count_r, dest};
    assign par_out_s  = par_r ^ {7'd0, inj_r};

    // Next-state and next-output decode for the transmit FSM.
    always_comb begin
        state_nxt    = state_r;
        data_nxt     = data_r;
        valid_nxt    = valid_r;
        rd_ptr_nxt   = rd_ptr_r;
        ld_count_nxt = ld_count_r;
        par_nxt      = par_r;
        err_nxt      = 1'b0;
        inj_nxt      = inj_r;
        wr_en_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // start has priority over a same-cycle load
                if (start) begin
                    if (start_ok_s) begin
                        state_nxt = ST_HEADER;
                        data_nxt  = header_s;
                        valid_nxt = 1'b1;
                        par_nxt   = par_r ^ header_s;
`ifdef ROUTER_TX_PARITY_INJ_EN
                        inj_nxt   = inj_err;
`else
                        inj_nxt   = 1'b0;
`endif
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (ld_en && !ld_full_s) begin
                    wr_en_s      = 1'b1;
                    ld_count_nxt = ld_count_r + 6'd1;
                    par_nxt      = par_r ^ ld_data;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (abort) begin
                    state_nxt    = ST_IDLE;
                    data_nxt     = 8'd0;
                    valid_nxt    = 1'b0;
                    ld_count_nxt = 6'd0;
                    par_nxt      = 8'd0;
                    inj_nxt      = 1'b0;
                end else if (!rtr.busy) begin
                    state_nxt  = ST_PAYLOAD;
                    rd_ptr_nxt = 6'd0;
                    data_nxt   = buf_mem[0];
                end else begin
                    state_nxt = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                if (abort) begin
                    state_nxt    = ST_IDLE;
                    data_nxt     = 8'd0;
                    valid_nxt    = 1'b0;
                    ld_count_nxt = 6'd0;
                    par_nxt      = 8'd0;
                    inj_nxt      = 1'b0;
                end else if (!rtr.busy) begin
                    // pkt_valid drops together with the parity byte
                    if (rd_ptr_r == (ld_count_r - 6'd1)) begin
                        state_nxt = ST_PARITY;
                        data_nxt  = par_out_s;
                        valid_nxt = 1'b0;
                    end else begin
                        rd_ptr_nxt = rd_ptr_r + 6'd1;
                        data_nxt   = buf_mem[rd_ptr_r + 6'd1];
                    end
                end else begin
                    state_nxt = ST_PAYLOAD;
                end
            end
            ST_PARITY: begin
                if (abort) begin
                    state_nxt    = ST_IDLE;
                    data_nxt     = 8'd0;
                    valid_nxt    = 1'b0;
                    ld_count_nxt = 6'd0;
                    par_nxt      = 8'd0;
                    inj_nxt      = 1'b0;
                end else if (!rtr.busy) begin
                    state_nxt = ST_DONE;
                    data_nxt  = 8'd0;
                end else begin
                    state_nxt = ST_PARITY;
                end
            end
            ST_DONE: begin
                state_nxt    = ST_IDLE;
                ld_count_nxt = 6'd0;
                par_nxt      = 8'd0;
                inj_nxt      = 1'b0;
            end
            default: begin
                state_nxt    = ST_IDLE;
                data_nxt     = 8'd0;
                valid_nxt    = 1'b0;
                ld_count_nxt = 6'd0;
                par_nxt      = 8'd0;
                inj_nxt      = 1'b0;
            end
        endcase
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            data_r     <= 8'd0;
            valid_r    <= 1'b0;
            rd_ptr_r   <= 6'd0;
            ld_count_r <= 6'd0;
            par_r      <= 8'd0;
            err_r      <= 1'b0;
            inj_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            data_r     <= data_nxt;
            valid_r    <= valid_nxt;
            rd_ptr_r   <= rd_ptr_nxt;
            ld_count_r <= ld_count_nxt;
            par_r      <= par_nxt;
            err_r      <= err_nxt;
            inj_r      <= inj_nxt;
        end
    end

    // Payload storage; emptiness is tracked by ld_count, so no reset is needed.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            buf_mem[ld_count_r] <= ld_data;
        end
    end

    assign rtr.data_out  = data_r;
    assign rtr.pkt_valid = valid_r;
    assign ld_count      = ld_count_r;
    assign ld_full       = ld_full_s;
    assign tx_active     = (state_r != ST_IDLE);
    assign done          = (state_r == ST_DONE);
    assign err           = err_r;

endmodule

// File: tb/tb_router_pkt_tx.sv
module tb_router_pkt_tx;
    localparam int MAX_LEN = 63;

    logic       clock = 1'b0;
    logic       reset;
    logic       ld_en;
    logic [7:0] ld_data;
    logic [5:0] ld_count;
    logic       ld_full;
    logic       start;
    logic [1:0] dest;
    logic       abort;
    logic       tx_active;
    logic       done;
    logic       err;
`ifdef ROUTER_TX_PARITY_INJ_EN
    logic       inj_err;
`endif

    int total = 0;
    int bad   = 0;

    // reference model: bytes the transmitter should currently hold
    logic [7:0] mq[$];

    router_pkt_tx_if rtr();

    router_pkt_tx #(.MAX_LEN(MAX_LEN)) dut (
        .clock     (clock),
        .reset     (reset),
        .ld_en     (ld_en),
        .ld_data   (ld_data),
        .ld_count  (ld_count),
        .ld_full   (ld_full),
        .start     (start),
        .dest      (dest),
        .abort     (abort),
        .tx_active (tx_active),
        .done      (done),
        .err       (err),
`ifdef ROUTER_TX_PARITY_INJ_EN
        .inj_err   (inj_err),
`endif
        .rtr       (rtr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [7:0] b);
        ld_en   = 1'b1;
        ld_data = b;
        step();
        ld_en   = 1'b0;
        if (mq.size() < MAX_LEN) mq.push_back(b);
    endtask

    // mode 0: busy never; 1: random busy; 2: busy two cycles after header accept
    task automatic send(input logic [1:0] dst, input int mode, input bit inj);
        logic [7:0] exp_q[$];
        logic [7:0] par;
        int n, idx, cyc, hold;
        n = mq.size();
        exp_q.push_back({n[5:0], dst});
        par = {n[5:0], dst};
        foreach (mq[k]) begin
            exp_q.push_back(mq[k]);
            par = par ^ mq[k];
        end
        exp_q.push_back(par ^ {7'd0, inj});

        start = 1'b1;
        dest  = dst;
`ifdef ROUTER_TX_PARITY_INJ_EN
        inj_err = inj;
`endif
        step();
        start = 1'b0;
        ld_en = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
        inj_err = 1'b0;
`endif
        idx = 0; cyc = 0; hold = 0;
        while (idx < n + 2 && cyc < 2000) begin
            case (mode)
                1:       rtr.busy = ($urandom_range(0, 3) == 0);
                2:       rtr.busy = (idx == 1 && hold < 2);
                default: rtr.busy = 1'b0;
            endcase
            if (rtr.busy && idx == 1) hold++;
            if (cyc > 1000) rtr.busy = 1'b0;
            // loads during transmission must be ignored
            ld_en   = 1'($urandom_range(0, 1));
            ld_data = 8'($urandom);
            chk("data_out", {24'd0, rtr.data_out}, {24'd0, exp_q[idx]});
            chk("pkt_valid", {31'd0, rtr.pkt_valid}, {31'd0, (idx <= n)});
            chk("tx_active", {31'd0, tx_active}, 32'd1);
            chk("done_low", {31'd0, done}, 32'd0);
            step();
            if (!rtr.busy) idx++;
            cyc++;
        end
        rtr.busy = 1'b0;
        ld_en    = 1'b0;
        chk("byte_budget", idx, n + 2);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_active", {31'd0, tx_active}, 32'd1);
        chk("done_valid", {31'd0, rtr.pkt_valid}, 32'd0);
        step();
        chk("done_end", {31'd0, done}, 32'd0);
        chk("idle_active", {31'd0, tx_active}, 32'd0);
        chk("idle_count", {26'd0, ld_count}, 32'd0);
        mq.delete();
    endtask

    initial begin
        reset = 1'b1; ld_en = 1'b0; ld_data = 8'd0; start = 1'b0;
        dest = 2'd0; abort = 1'b0; rtr.busy = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
        inj_err = 1'b0;
`endif
        #12;
        chk("rst_data", {24'd0, rtr.data_out}, 32'd0);
        chk("rst_valid", {31'd0, rtr.pkt_valid}, 32'd0);
        chk("rst_active", {31'd0, tx_active}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_count", {26'd0, ld_count}, 32'd0);
        chk("rst_full", {31'd0, ld_full}, 32'd0);
        reset = 1'b0;
        step();

        // basic packet, no back-pressure
        load(8'h11); load(8'h22); load(8'h33);
        chk("ld_count3", {26'd0, ld_count}, 32'd3);
        send(2'd1, 0, 1'b0);

        // same packet, two busy cycles after the header is accepted
        load(8'h11); load(8'h22); load(8'h33);
        send(2'd1, 2, 1'b0);

        // rejected start: empty buffer
        start = 1'b1; dest = 2'd1; step(); start = 1'b0;
        chk("err_empty", {31'd0, err}, 32'd1);
        chk("err_empty_act", {31'd0, tx_active}, 32'd0);
        chk("err_empty_cnt", {26'd0, ld_count}, 32'd0);
        step();
        chk("err_clear", {31'd0, err}, 32'd0);

        // rejected start: dest 3, buffer kept
        load(8'hA1); load(8'hB2);
        start = 1'b1; dest = 2'd3; step(); start = 1'b0;
        chk("err_dest", {31'd0, err}, 32'd1);
        chk("err_dest_act", {31'd0, tx_active}, 32'd0);
        chk("err_dest_cnt", {26'd0, ld_count}, 32'd2);
        step();
        chk("err_dest_clr", {31'd0, err}, 32'd0);

        // start together with ld_en: the load is dropped
        ld_en = 1'b1; ld_data = 8'hEE;
        send(2'd2, 1, 1'b0);

        // full buffer: 64th load ignored
        for (int k = 0; k < 64; k++) load(8'($urandom));
        chk("full_flag", {31'd0, ld_full}, 32'd1);
        chk("full_count", {26'd0, ld_count}, 32'd63);
        send(2'($urandom_range(0, 2)), 1, 1'b0);

        // random packets with random back-pressure
        for (int p = 0; p < 4; p++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++) load(8'($urandom));
            send(2'($urandom_range(0, 2)), 1, 1'b0);
        end

        // abort in IDLE has no effect; abort on second payload byte
        for (int k = 0; k < 4; k++) load(8'($urandom));
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_idle_cnt", {26'd0, ld_count}, 32'd4);
        start = 1'b1; dest = 2'd0; step(); start = 1'b0;
        chk("ab_header", {24'd0, rtr.data_out}, {24'd0, 6'd4, 2'd0});
        step();
        chk("ab_pay0", {24'd0, rtr.data_out}, {24'd0, mq[0]});
        step();
        chk("ab_pay1", {24'd0, rtr.data_out}, {24'd0, mq[1]});
        chk("ab_valid1", {31'd0, rtr.pkt_valid}, 32'd1);
        abort = 1'b1; step(); abort = 1'b0;
        chk("ab_active", {31'd0, tx_active}, 32'd0);
        chk("ab_valid", {31'd0, rtr.pkt_valid}, 32'd0);
        chk("ab_done", {31'd0, done}, 32'd0);
        chk("ab_count", {26'd0, ld_count}, 32'd0);
        step();
        chk("ab_done2", {31'd0, done}, 32'd0);
        mq.delete();

        // asynchronous reset mid-payload
        load(8'h01); load(8'h02); load(8'h03);
        start = 1'b1; dest = 2'd2; step(); start = 1'b0;
        step(); step();
        chk("pre_rst_valid", {31'd0, rtr.pkt_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, rtr.pkt_valid}, 32'd0);
        chk("arst_data", {24'd0, rtr.data_out}, 32'd0);
        chk("arst_active", {31'd0, tx_active}, 32'd0);
        chk("arst_count", {26'd0, ld_count}, 32'd0);
        reset = 1'b0;
        mq.delete();
        step();

        // recovery packet after reset
        load(8'h5A); load(8'hC3);
        send(2'd0, 1, 1'b0);

`ifdef ROUTER_TX_PARITY_INJ_EN
        load(8'h5A);
        send(2'd2, 0, 1'b1);
        load(8'h5A);
        send(2'd2, 0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
